display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter GUARD_CYC, default 8: blanking cycles at the start of each slot; SHALL satisfy 0 < GUARD_CYC < SCAN_DIV.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-low.
REQ-005 value  input  16  four BCD nibbles; digit 0 = [3:0], digit 3 = [15:12].
REQ-006 load  input  1  one-cycle strobe that captures value into the shadow register.
REQ-007 bcd  output  4  nibble of the currently selected digit; drives the BCD-to-seven-segment decoder.
REQ-008 an  output  4  active-low digit enables; an[i]=0 lights digit i.
REQ-009 ack  output  1  one-cycle pulse when shadow data is committed to the display register.
REQ-010 frame_tick  output  1  one-cycle pulse when digit index wraps 3->0.

Function
REQ-011 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; a wrap ends the slot.
REQ-012 State SHALL be GUARD while cnt < GUARD_CYC, otherwise DISP.
REQ-013 In GUARD, an SHALL be 4'b1111; in DISP, an SHALL be all ones except bit idx = 0.
REQ-014 bcd SHALL equal disp_reg nibble idx in both states; an and bcd SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-015 At each slot end, idx SHALL increment modulo 4.
REQ-016 On the slot end where idx goes 3->0, frame_tick SHALL be 1 for exactly that cycle.
REQ-017 load=1 SHALL write value into shadow and set pending; a later load before commit overwrites shadow (last write wins).
REQ-018 At the frame wrap with pending=1, disp_reg <= shadow, pending cleared, and ack=1 for that cycle; no tearing within a frame.
REQ-019 load coincident with a commit: old shadow SHALL be committed, the new value SHALL be stored in shadow, and pending SHALL remain 1; ack still pulses.
REQ-020 Frame wrap with pending=0: disp_reg unchanged, ack=0.
REQ-021 Frame period SHALL be exactly 4*SCAN_DIV cycles; ack-to-visible latency SHALL be GUARD_CYC cycles (new data appears on digit 0 at first DISP cycle).

Reset
REQ-022 rst=0 at a clock edge SHALL set cnt=0, idx=0, state GUARD, shadow=0, disp_reg=0, pending=0.
REQ-023 During and immediately after reset: an=4'b1111, bcd=4'h0, ack=0, frame_tick=0.
REQ-024 Reset mid-frame SHALL discard any pending load; the first frame after reset begins at digit 0 slot, cnt=0.
REQ-025 load asserted while rst=0 SHALL be ignored.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN defined: in DISP, digit i (i=1..3) SHALL be kept dark (an all ones) when disp_reg nibbles i..3 are all zero; digit 0 always lit.
REQ-027 Macro undefined: all four digits SHALL be lit in their DISP windows regardless of value; no other behaviour changes.

Verification (SCAN_DIV=8, GUARD_CYC=2)
REQ-028 Release reset, no load -> an=1111 for cycles 0-1, an=1110 cycles 2-7, an=1101 cycles 10-15; bcd=0; frame_tick at cycle 31 (the 3->0 wrap), repeats every 32 cycles.
REQ-029 load value=16'h1234 mid-frame -> disp_reg unchanged until frame wrap; ack and frame_tick same cycle; next digit-0 DISP shows bcd=4, digit 3 shows bcd=1.
REQ-030 Two loads 16'h1111 then 16'h2222 within one frame -> single ack; displayed value 16'h2222.
REQ-031 load 16'h5678 on exact commit cycle with pending 16'h0009 -> 16'h0009 committed with ack; pending stays 1; 16'h5678 committed with ack at next wrap.
REQ-032 rst=0 for one cycle during digit 2 slot with pending load -> outputs return to reset values; no ack at the following wrap; scan restarts at digit 0.
REQ-033 value 16'h0042 committed: with LEADING_ZERO_BLANK_EN, an stays 1111 in digit 2 and 3 slots; without it, an=1011 and 0111 with bcd=0.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit BCD display scanner with guard blanking and frame-synchronous commit.
// Optional macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned GUARD_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        ack,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DISP  = 1'b1
  } state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      disp_q, disp_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             ack_q, ack_d;
  logic             frame_tick_q, frame_tick_d;

  state_e           state_c;
  logic             slot_end_c;
  logic             wrap_c;
  logic             commit_c;
  logic             dark_c;

  // Next-state and registered-output decode; outputs follow the next state so they
  // line up with cnt_q/idx_q/disp_q in the same cycle.
  always_comb begin
    slot_end_c   = 1'b0;
    wrap_c       = 1'b0;
    commit_c     = 1'b0;
    dark_c       = 1'b0;
    state_c      = ST_GUARD;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    an_d         = 4'b1111;
    bcd_d        = 4'h0;
    ack_d        = 1'b0;
    frame_tick_d = 1'b0;

    slot_end_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
    wrap_c     = slot_end_c && (idx_q == IDX_W'(3));
    commit_c   = wrap_c && pending_q;

    cnt_d = slot_end_c ? '0 : cnt_q + CNT_W'(1);
    idx_d = slot_end_c ? idx_q + IDX_W'(1) : idx_q;

    // Commit uses the old shadow; a coincident load refills shadow and re-arms pending.
    if (commit_c) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    state_c = (cnt_d < CNT_W'(GUARD_CYC)) ? ST_GUARD : ST_DISP;

`ifdef LEADING_ZERO_BLANK_EN
    dark_c = (idx_d != IDX_W'(0)) && ((disp_d >> {idx_d, 2'b00}) == 16'h0000);
`else
    dark_c = 1'b0;
`endif

    if (state_c == ST_DISP && !dark_c) begin
      an_d[idx_d] = 1'b0;
    end
    bcd_d = disp_d[{idx_d, 2'b00} +: 4];

    frame_tick_d = (cnt_d == CNT_W'(SCAN_DIV - 1)) && (idx_d == IDX_W'(3));
    ack_d        = frame_tick_d && pending_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      an_q         <= 4'b1111;
      bcd_q        <= 4'h0;
      ack_q        <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      ack_q        <= ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign bcd        = bcd_q;
  assign ack        = ack_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random loads/resets against a
// cycle-index reference model (SCAN_DIV=8, GUARD_CYC=2).
module tb_display_scan_ctrl;

  localparam int unsigned SD    = 8;
  localparam int unsigned GC    = 2;
  localparam int unsigned FRAME = 4 * SD;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        ack;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  // Reference model: cycles since reset release plus the data registers.
  int          m_t      = 0;
  logic [15:0] m_disp   = '0;
  logic [15:0] m_shadow = '0;
  logic        m_pend   = 1'b0;
  bit          m_valid  = 1'b0;
  int          ack_seen = 0;

  display_scan_ctrl #(.SCAN_DIV(SD), .GUARD_CYC(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .bcd        (bcd),
    .an         (an),
    .ack        (ack),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_an(input int t, input logic [15:0] d);
    int          cnt;
    int          dig;
    logic [3:0]  r;
    logic [15:0] upper;
    cnt   = t % SD;
    dig   = (t / SD) % 4;
    r     = 4'b1111;
    upper = d >> (4 * dig);
    if (cnt >= GC) begin
      r[dig] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (dig != 0 && upper == 16'h0000) r = 4'b1111;
`endif
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_bcd(input int t, input logic [15:0] d);
    logic [15:0] s;
    s = d >> (4 * ((t / SD) % 4));
    return s[3:0];
  endfunction

  // Compare outputs at the falling edge, drive inputs, then advance the model at the rising edge.
  task automatic step(input logic r, input logic ld, input logic [15:0] v);
    logic [3:0] e_an;
    logic [3:0] e_bcd;
    logic       e_ft;
    logic       e_ack;
    @(negedge clk);
    if (m_valid) begin
      e_an  = exp_an(m_t, m_disp);
      e_bcd = exp_bcd(m_t, m_disp);
      e_ft  = ((m_t % FRAME) == FRAME - 1);
      e_ack = e_ft && m_pend;
      checks += 4;
      assert (an === e_an) else begin
        failures++;
        $error("FAIL an t=%0d observed=%b expected=%b", m_t, an, e_an);
      end
      assert (bcd === e_bcd) else begin
        failures++;
        $error("FAIL bcd t=%0d observed=%h expected=%h", m_t, bcd, e_bcd);
      end
      assert (frame_tick === e_ft) else begin
        failures++;
        $error("FAIL frame_tick t=%0d observed=%b expected=%b", m_t, frame_tick, e_ft);
      end
      assert (ack === e_ack) else begin
        failures++;
        $error("FAIL ack t=%0d observed=%b expected=%b", m_t, ack, e_ack);
      end
      if (ack === 1'b1) ack_seen++;
    end
    rst   = r;
    load  = ld;
    value = v;
    @(posedge clk);
    if (!r) begin
      m_t      = 0;
      m_disp   = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      m_valid  = 1'b1;
    end else begin
      if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_shadow = v;
        m_pend   = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000);
  endtask

  task automatic idle_until(input int phase);
    for (int i = 0; i < FRAME; i++) begin
      if ((m_t % FRAME) == phase) break;
      step(1'b1, 1'b0, 16'h0000);
    end
  endtask

  initial begin
    rst   = 1'b0;
    load  = 1'b0;
    value = 16'h0000;

    // Reset held for several edges, with a load that must be ignored.
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'hABCD);
    step(1'b0, 1'b0, 16'h0000);

    // Free-running scan with blank data across two frames.
    idle(2 * FRAME + 4);

    // Mid-frame load; committed at the wrap and then shown digit by digit.
    idle_until(10);
    step(1'b1, 1'b1, 16'h1234);
    idle(2 * FRAME);

    // Two loads in one frame: last write wins, single ack.
    ack_seen = 0;
    idle_until(3);
    step(1'b1, 1'b1, 16'h1111);
    idle(5);
    step(1'b1, 1'b1, 16'h2222);
    idle(FRAME + 4);
    checks++;
    assert (ack_seen == 1) else begin
      failures++;
      $error("FAIL single_ack observed=%0d expected=%0d", ack_seen, 1);
    end

    // Load landing exactly on the commit cycle with another value pending.
    idle_until(5);
    step(1'b1, 1'b1, 16'h0009);
    idle_until(FRAME - 1);
    step(1'b1, 1'b1, 16'h5678);
    idle(2 * FRAME);

    // One-cycle reset during digit 2 slot with a pending load.
    idle_until(2);
    step(1'b1, 1'b1, 16'h7777);
    idle_until(2 * SD + 3);
    step(1'b0, 1'b0, 16'h0000);
    idle(2 * FRAME);

    // Leading-zero case.
    idle_until(4);
    step(1'b1, 1'b1, 16'h0042);
    idle(2 * FRAME);

    // Random loads and occasional resets.
    for (int i = 0; i < 700; i++) begin
      logic        r;
      logic        ld;
      logic [15:0] v;
      r  = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 11) == 0);
      v  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v[15:8] = 8'h00;
      step(r, ld, v);
    end
    idle(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
